// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel-source read request
// Line order is front porch, sync, back porch, active; the visible region sits at bottom-right of the counter space.
module vga_timing_gen #(
  parameter int COLOR_W = 8,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ACT   = 640,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ACT   = 480,
  parameter int H_POL   = 0,
  parameter int V_POL   = 0,
  parameter int RD_LEAD = 2,
  parameter int V_MARK  = 0
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iEN,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic [COLOR_W-1:0] oVGA_R,
  output logic [COLOR_W-1:0] oVGA_G,
  output logic [COLOR_W-1:0] oVGA_B,
  output logic               oVGA_H_SYNC,
  output logic               oVGA_V_SYNC,
  output logic               oVGA_BLANK,
  output logic               oVGA_SYNC,
  output logic               oVGA_CLOCK,
  output logic               oREAD_Request,
  output logic [15:0]        oX,
  output logic [15:0]        oY,
  output logic               oFrame_Start,
  output logic               oLine_Start
);

  localparam logic [15:0] H_BLANK    = 16'(H_FP + H_SYNC + H_BP);
  localparam logic [15:0] H_LAST     = 16'(H_FP + H_SYNC + H_BP + H_ACT - 1);
  localparam logic [15:0] HS_START   = 16'(H_FP);
  localparam logic [15:0] HS_END     = 16'(H_FP + H_SYNC);
  localparam logic [15:0] V_BLANK    = 16'(V_FP + V_SYNC + V_BP);
  localparam logic [15:0] V_LAST     = 16'(V_FP + V_SYNC + V_BP + V_ACT - 1);
  localparam logic [15:0] VS_START   = 16'(V_FP);
  localparam logic [15:0] VS_END     = 16'(V_FP + V_SYNC);
  localparam logic [15:0] V_VISIBLE  = 16'(V_FP + V_SYNC + V_BP + V_MARK);
  // Requests run RD_LEAD ticks ahead of the pixel column they fetch.
  localparam logic [15:0] RD_FIRST   = 16'(H_FP + H_SYNC + H_BP - RD_LEAD);
  localparam logic [15:0] RD_LAST    = 16'(H_FP + H_SYNC + H_BP + H_ACT - 1 - RD_LEAD);
  localparam logic        HS_ON      = (H_POL != 0);
  localparam logic        VS_ON      = (V_POL != 0);

  logic [15:0]        h_q, h_d, v_q, v_d;
  logic               hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [15:0]        x_q, x_d, y_q, y_d;
  logic               fs_q, fs_d, ls_q, ls_d;
  logic               active, line_visible, visible;

  assign active       = (h_q >= H_BLANK) && (v_q >= V_BLANK);
  assign line_visible = (v_q >= V_VISIBLE);
  assign visible      = active && line_visible;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (iEN) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 16'd1;
      end else begin
        h_d = h_q + 16'd1;
      end
    end
  end

  always_comb begin
    hs_d    = ((h_q >= HS_START) && (h_q < HS_END)) ? HS_ON : ~HS_ON;
    vs_d    = ((v_q >= VS_START) && (v_q < VS_END)) ? VS_ON : ~VS_ON;
    blank_d = active;
    r_d     = visible ? iRed   : '0;
    g_d     = visible ? iGreen : '0;
    b_d     = visible ? iBlue  : '0;
    x_d     = active ? (h_q - H_BLANK) : '0;
    y_d     = active ? (v_q - V_BLANK) : '0;
    fs_d    = (h_q == 16'd0) && (v_q == 16'd0);
    ls_d    = (h_q == 16'd0);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      h_q     <= '0;
      v_q     <= '0;
      hs_q    <= ~HS_ON;
      vs_q    <= ~VS_ON;
      blank_q <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else if (iEN) begin
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
    end
  end

  assign oREAD_Request = iRST_N && iEN && line_visible && (h_q >= RD_FIRST) && (h_q <= RD_LAST);
  assign oVGA_R        = r_q;
  assign oVGA_G        = g_q;
  assign oVGA_B        = b_q;
  assign oVGA_H_SYNC   = hs_q;
  assign oVGA_V_SYNC   = vs_q;
  assign oVGA_BLANK    = blank_q;
  assign oX            = x_q;
  assign oY            = y_q;
  assign oFrame_Start  = fs_q;
  assign oLine_Start   = ls_q;
  assign oVGA_SYNC     = 1'b0;
  assign oVGA_CLOCK    = iCLK;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen on a 14x7 raster
module tb_vga_timing_gen;

  localparam int HB = 6, HT = 14, VB = 3, VT = 7, RD_LEAD = 2;

  typedef struct packed {
    logic        hs, vs, blank;
    logic [7:0]  r, g, b;
    logic [15:0] x, y;
    logic        fs, ls;
  } exp_t;

  typedef struct {
    int h; int req; int hs; int blank; int r; int x; int ls;
  } row_t;

  logic       iCLK, iRST_N, iEN;
  logic [7:0] iRed, iGreen, iBlue;
  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic       hs0, vs0, bl0, sy0, ck0, rq0, fs0, ls0;
  logic       hs1, vs1, bl1, sy1, ck1, rq1, fs1, ls1;
  logic [15:0] x0, y0, x1, y1;

  vga_timing_gen #(.COLOR_W(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .H_ACT(8),
                   .V_FP(1), .V_SYNC(1), .V_BP(1), .V_ACT(4), .H_POL(0), .V_POL(0),
                   .RD_LEAD(RD_LEAD), .V_MARK(0)) dut0 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .oVGA_R(r0), .oVGA_G(g0), .oVGA_B(b0), .oVGA_H_SYNC(hs0), .oVGA_V_SYNC(vs0),
    .oVGA_BLANK(bl0), .oVGA_SYNC(sy0), .oVGA_CLOCK(ck0), .oREAD_Request(rq0),
    .oX(x0), .oY(y0), .oFrame_Start(fs0), .oLine_Start(ls0));

  vga_timing_gen #(.COLOR_W(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .H_ACT(8),
                   .V_FP(1), .V_SYNC(1), .V_BP(1), .V_ACT(4), .H_POL(0), .V_POL(0),
                   .RD_LEAD(RD_LEAD), .V_MARK(1)) dut1 (
    .iCLK(iCLK), .iRST_N(iRST_N), .iEN(iEN), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .oVGA_R(r1), .oVGA_G(g1), .oVGA_B(b1), .oVGA_H_SYNC(hs1), .oVGA_V_SYNC(vs1),
    .oVGA_BLANK(bl1), .oVGA_SYNC(sy1), .oVGA_CLOCK(ck1), .oREAD_Request(rq1),
    .oX(x1), .oY(y1), .oFrame_Start(fs1), .oLine_Start(ls1));

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int   n_chk, n_fail;
  int   mh, mv, mframe, step_idx, n_rise, req_noen;
  int   fs_rise[4];
  int   req0[VT], req1[VT];
  int   hs_low, hs_first, vs_low, blank1_v3, rgb1_nz_v3;
  logic acc, prev_fs, smp_rq0;
  exp_t last0, last1;
  exp_t sb0[$], sb1[$];
  row_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cmp(input string p, input exp_t a, input exp_t e);
    chk({p, ".hsync"}, a.hs, e.hs);
    chk({p, ".vsync"}, a.vs, e.vs);
    chk({p, ".blank"}, a.blank, e.blank);
    chk({p, ".r"}, a.r, e.r);
    chk({p, ".g"}, a.g, e.g);
    chk({p, ".b"}, a.b, e.b);
    chk({p, ".x"}, a.x, e.x);
    chk({p, ".y"}, a.y, e.y);
    chk({p, ".frame_start"}, a.fs, e.fs);
    chk({p, ".line_start"}, a.ls, e.ls);
  endtask

  function automatic exp_t model(int h, int v, logic [7:0] r, int vm);
    exp_t e;
    logic act, vis;
    act     = (h >= HB) && (v >= VB);
    vis     = act && (v >= VB + vm);
    e.hs    = !((h >= 2) && (h < 4));
    e.vs    = !((v >= 1) && (v < 2));
    e.blank = act;
    e.r     = vis ? r : 8'd0;
    e.g     = vis ? (r ^ 8'h5A) : 8'd0;
    e.b     = vis ? ~r : 8'd0;
    e.x     = act ? 16'(h - HB) : 16'd0;
    e.y     = act ? 16'(v - VB) : 16'd0;
    e.fs    = (h == 0) && (v == 0);
    e.ls    = (h == 0);
    return e;
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; mframe = 0; step_idx = 0; n_rise = 0; prev_fs = 1'b0;
    for (int i = 0; i < 4; i++) fs_rise[i] = -1;
    last0 = '{hs: 1'b1, vs: 1'b1, default: '0};
    last1 = last0;
    sb0.delete(); sb1.delete();
  endtask

  task automatic chk_reset_one(input string p, input logic hs, input logic vs, input logic bl,
                               input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                               input logic [15:0] x, input logic [15:0] y, input logic rq,
                               input logic fs, input logic ls);
    chk({p, ".hsync"}, hs, 1);
    chk({p, ".vsync"}, vs, 1);
    chk({p, ".blank"}, bl, 0);
    chk({p, ".rgb"}, {r, g, b}, 0);
    chk({p, ".x"}, x, 0);
    chk({p, ".y"}, y, 0);
    chk({p, ".read_req"}, rq, 0);
    chk({p, ".frame_start"}, fs, 0);
    chk({p, ".line_start"}, ls, 0);
  endtask

  // One pixel-clock cycle: drive at negedge, check the combinational request, sample after the edge.
  task automatic step(input logic en, input logic [7:0] r);
    exp_t e0, e1, a0, a1;
    logic xr0, xr1;
    int   ph, pv, pf;
    iEN = en; iRed = r; iGreen = r ^ 8'h5A; iBlue = ~r;
    #1;
    ph = mh; pv = mv; pf = mframe;
    xr0 = en && (pv >= VB) && (ph >= HB - RD_LEAD) && (ph <= HT - 1 - RD_LEAD);
    xr1 = en && (pv >= VB + 1) && (ph >= HB - RD_LEAD) && (ph <= HT - 1 - RD_LEAD);
    chk("read_req0", rq0, xr0);
    chk("read_req1", rq1, xr1);
    smp_rq0 = rq0;
    if (acc && en && pf == 0) begin
      if (rq0) req0[pv]++;
      if (rq1) req1[pv]++;
    end
    if (!en && (rq0 || rq1)) req_noen++;
    if (en) begin
      e0 = model(ph, pv, r, 0);
      e1 = model(ph, pv, r, 1);
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin mv = 0; mframe++; end
        else mv++;
      end else mh++;
    end else begin
      e0 = last0;
      e1 = last1;
    end
    sb0.push_back(e0); sb1.push_back(e1);
    last0 = e0; last1 = e1;
    @(posedge iCLK);
    @(negedge iCLK);
    a0 = {hs0, vs0, bl0, r0, g0, b0, x0, y0, fs0, ls0};
    a1 = {hs1, vs1, bl1, r1, g1, b1, x1, y1, fs1, ls1};
    cmp("dut0", a0, sb0.pop_front());
    cmp("dut1", a1, sb1.pop_front());
    chk("vga_sync", {sy0, sy1}, 0);
    chk("vga_clock", {ck0, ck1}, {iCLK, iCLK});
    if (acc && en && pf == 0) begin
      if (pv == 0 && !hs0) begin
        if (hs_first < 0) hs_first = ph;
        hs_low++;
      end
      if (!vs0) vs_low++;
      if (pv == 3 && bl1) begin
        blank1_v3++;
        if ({r1, g1, b1} != 24'd0) rgb1_nz_v3++;
      end
    end
    if (fs0 && !prev_fs && n_rise < 4) begin
      fs_rise[n_rise] = step_idx;
      n_rise++;
    end
    prev_fs = fs0;
    step_idx++;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; acc = 1'b0; req_noen = 0;
    hs_low = 0; hs_first = -1; vs_low = 0; blank1_v3 = 0; rgb1_nz_v3 = 0;
    for (int i = 0; i < VT; i++) begin req0[i] = 0; req1[i] = 0; end

    // Line v=3 of the unmasked instance, iRed driven with h.
    tbl[0]  = '{0,  0, 1, 0, 0,  0, 1};
    tbl[1]  = '{1,  0, 1, 0, 0,  0, 0};
    tbl[2]  = '{2,  0, 0, 0, 0,  0, 0};
    tbl[3]  = '{3,  0, 0, 0, 0,  0, 0};
    tbl[4]  = '{4,  1, 1, 0, 0,  0, 0};
    tbl[5]  = '{5,  1, 1, 0, 0,  0, 0};
    tbl[6]  = '{6,  1, 1, 1, 6,  0, 0};
    tbl[7]  = '{7,  1, 1, 1, 7,  1, 0};
    tbl[8]  = '{8,  1, 1, 1, 8,  2, 0};
    tbl[9]  = '{9,  1, 1, 1, 9,  3, 0};
    tbl[10] = '{10, 1, 1, 1, 10, 4, 0};
    tbl[11] = '{11, 1, 1, 1, 11, 5, 0};
    tbl[12] = '{12, 0, 1, 1, 12, 6, 0};
    tbl[13] = '{13, 0, 1, 1, 13, 7, 0};

    iRST_N = 1'b0; iEN = 1'b1; iRed = 8'hFF; iGreen = 8'hFF; iBlue = 8'hFF;
    model_reset();
    repeat (3) @(negedge iCLK);
    chk_reset_one("reset0", hs0, vs0, bl0, r0, g0, b0, x0, y0, rq0, fs0, ls0);
    chk_reset_one("reset1", hs1, vs1, bl1, r1, g1, b1, x1, y1, rq1, fs1, ls1);
    iRST_N = 1'b1;

    acc = 1'b1;
    for (int i = 0; i < 3 * HT; i++) step(1'b1, 8'(mh));
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 8'(tbl[i].h));
      chk("tbl.read_req", smp_rq0, tbl[i].req);
      chk("tbl.hsync", hs0, tbl[i].hs);
      chk("tbl.blank", bl0, tbl[i].blank);
      chk("tbl.r", r0, tbl[i].r);
      chk("tbl.x", x0, tbl[i].x);
      chk("tbl.y", y0, 0);
      chk("tbl.line_start", ls0, tbl[i].ls);
    end
    // Finish at (v=4, h=8) of frame 2, mid-way through a visible line.
    for (int i = 4 * HT; i < 2 * HT * VT + 4 * HT + 8; i++) step(1'b1, 8'(mh));
    acc = 1'b0;

    chk("first_frame_start_tick", fs_rise[0], 0);
    chk("frame_period", fs_rise[1] - fs_rise[0], HT * VT);
    chk("req_lines_0_2", req0[0] + req0[1] + req0[2], 0);
    chk("req_line3", req0[3], 8);
    chk("req_line6", req0[6], 8);
    chk("hsync_low_ticks", hs_low, 2);
    chk("hsync_first_h", hs_first, 2);
    chk("vsync_low_ticks", vs_low, HT);
    chk("mark_req_line3", req1[3], 0);
    chk("mark_req_line4", req1[4], 8);
    chk("mark_blank_line3", blank1_v3, 8);
    chk("mark_rgb_nonzero_line3", rgb1_nz_v3, 0);

    // Asynchronous reset in the middle of a visible line, with iEN held high.
    iEN = 1'b1; iRed = 8'hA5; iGreen = 8'hA5; iBlue = 8'hA5;
    #1;
    chk("pre_reset_read_req", rq0, 1);
    iRST_N = 1'b0;
    #1;
    chk_reset_one("midrst0", hs0, vs0, bl0, r0, g0, b0, x0, y0, rq0, fs0, ls0);
    chk_reset_one("midrst1", hs1, vs1, bl1, r1, g1, b1, x1, y1, rq1, fs1, ls1);
    @(negedge iCLK);
    iRST_N = 1'b1;
    model_reset();

    // Half-rate enable: every period doubles and requests never appear on idle cycles.
    for (int i = 0; i < 2 * HT * VT + 4; i++) step((i % 2) == 0, 8'(mh));
    chk("restart_frame_start_tick", fs_rise[0], 0);
    chk("half_rate_frame_period", fs_rise[1] - fs_rise[0], 2 * HT * VT);
    chk("req_without_enable", req_noen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter COLOR_W, default 8, meaning width of each colour channel.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, H_ACT, defaults 16, 96, 48, 640, meaning horizontal front porch, sync, back porch and active widths in pixel ticks.
REQ-003 SHALL have parameters V_FP, V_SYNC, V_BP, V_ACT, defaults 10, 2, 33, 480, meaning vertical porch, sync and active heights in lines.
REQ-004 SHALL have parameters H_POL and V_POL, default 0, meaning sync active level (0 = active-low).
REQ-005 SHALL have parameter RD_LEAD, default 2, meaning pixel-source read latency in ticks; legal range 1..H_FP+H_SYNC+H_BP-1.
REQ-006 SHALL have parameter V_MARK, default 0, meaning active lines at the top of the frame that are masked.
REQ-007 SHALL have ports, in order: iCLK in 1 pixel clock; iRST_N in 1 reset; iEN in 1 pixel-tick enable; iRed, iGreen, iBlue in COLOR_W each, pixel data; oVGA_R, oVGA_G, oVGA_B out COLOR_W each; oVGA_H_SYNC out 1; oVGA_V_SYNC out 1; oVGA_BLANK out 1, active-low blank; oVGA_SYNC out 1; oVGA_CLOCK out 1; oREAD_Request out 1; oX out 16, pixel column; oY out 16, pixel row; oFrame_Start out 1; oLine_Start out 1.
REQ-008 SHALL use one clock, iCLK, and reset iRST_N, asynchronous and active-low.

Function
REQ-009 SHALL define H_BLANK=H_FP+H_SYNC+H_BP, H_TOTAL=H_BLANK+H_ACT, and likewise V_BLANK, V_TOTAL.
REQ-010 SHALL keep a 16-bit counter h that advances only on ticks with iEN=1, wrapping from H_TOTAL-1 to 0, and a 16-bit counter v that advances only on that wrap, wrapping from V_TOTAL-1 to 0.
REQ-011 SHALL hold all counters and registered outputs unchanged on any cycle with iEN=0.
REQ-012 SHALL order each line as front porch, sync, back porch, active; h-sync is active for H_FP <= h < H_FP+H_SYNC; v-sync is the same with the V parameters.
REQ-013 SHALL register oVGA_H_SYNC, oVGA_V_SYNC and oVGA_BLANK from the counter state, one enabled tick of latency, with the polarity set by H_POL/V_POL.
REQ-014 SHALL define active as h >= H_BLANK and v >= V_BLANK; oVGA_BLANK SHALL be 1 only when the registered active is true.
REQ-015 SHALL define visible as active and v >= V_BLANK+V_MARK.
REQ-016 SHALL drive oREAD_Request combinationally high when H_BLANK-RD_LEAD <= h <= H_TOTAL-1-RD_LEAD and the current line is visible, and iEN=1; exactly H_ACT requests per visible line.
REQ-017 SHALL treat iRed/iGreen/iBlue as valid RD_LEAD enabled ticks after the matching request and register them into oVGA_R/G/B when visible; otherwise the colour outputs SHALL register 0.
REQ-018 SHALL register oX=h-H_BLANK and oY=v-V_BLANK aligned with the colour outputs when active; both SHALL be 0 otherwise.
REQ-019 SHALL pulse oFrame_Start for one enabled tick, aligned with the outputs, for counter state (0,0); oLine_Start SHALL pulse the same way for h=0.
REQ-020 SHALL tie oVGA_SYNC to 0 and drive oVGA_CLOCK from iCLK.

Reset
REQ-021 SHALL, while iRST_N=0, force h=v=0, both syncs to their inactive level, oVGA_BLANK=0, RGB=0, oX=oY=0, oREAD_Request=0, oFrame_Start=oLine_Start=0.
REQ-022 SHALL, after a mid-frame reset release, restart at h=v=0 with the first oFrame_Start on the first enabled tick.

Verification (params H 2/2/2/8, V 1/1/1/4, RD_LEAD=2, V_MARK=0, iEN=1 unless stated)
REQ-023 SHALL check: reset release -> oFrame_Start=1 on the first registered tick; the next oFrame_Start comes 98 ticks later (H_TOTAL=14, V_TOTAL=7).
REQ-024 SHALL check: on line v=3 -> oREAD_Request high for h=4..11 (8 ticks); low on lines v=0..2.
REQ-025 SHALL check: iRed=h on each tick -> oVGA_R shows 6,7,...,13 on the 8 blank-deasserted ticks, with oX=0..7; RGB=0 elsewhere.
REQ-026 SHALL check: H_POL=0 -> oVGA_H_SYNC low for exactly 2 ticks per line, one tick after h=2; oVGA_V_SYNC low for 14 ticks during line v=1.
REQ-027 SHALL check: iEN toggled 1,0,1,0 -> counters and outputs advance only on iEN=1; all periods double; oREAD_Request only with iEN=1.
REQ-028 SHALL check: V_MARK=1 -> no requests and RGB=0 on v=3 while oVGA_BLANK=1; normal from v=4; iRST_N pulsed low mid-line -> all outputs at their REQ-021 values immediately.
